// File: rtl/button_debouncer.sv
// Two-flop synchronizer plus four-state debounce FSM with press/release strobes.
// Optional long-press strobe is built when BUTTON_DEBOUNCER_LONG_PRESS_EN is defined.
module button_debouncer #(
  parameter int DEBOUNCE_CYCLES   = 250000,
  parameter int LONG_PRESS_CYCLES = 1000000,
  parameter int CNT_W             = 21
) (
  input  logic clk,
  input  logic rst,
  input  logic button_raw,
  output logic button_clean,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_press
);

  typedef enum logic [1:0] {
    S_LOW       = 2'd0,
    S_RISE_WAIT = 2'd1,
    S_HIGH      = 2'd2,
    S_FALL_WAIT = 2'd3
  } state_t;

  localparam logic [CNT_W:0] DEB_LIM = (CNT_W + 1)'(DEBOUNCE_CYCLES);

  state_t           state;
  logic             sync1;
  logic             sync2;
  logic [CNT_W-1:0] count;
  logic [CNT_W:0]   count_inc;
  logic             count_done;

  // One extra bit so the compare can never be fooled by a wrapped increment.
  assign count_inc  = {1'b0, count} + (CNT_W + 1)'(1);
  assign count_done = (count_inc >= DEB_LIM);

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1         <= 1'b0;
      sync2         <= 1'b0;
      state         <= S_LOW;
      count         <= '0;
      button_clean  <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      sync1         <= button_raw;
      sync2         <= sync1;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      case (state)
        S_LOW: begin
          if (sync2) begin
            state <= S_RISE_WAIT;
            count <= CNT_W'(1);
          end else begin
            count <= '0;
          end
        end
        S_RISE_WAIT: begin
          if (!sync2) begin
            state <= S_LOW;
            count <= '0;
          end else if (count_done) begin
            state        <= S_HIGH;
            count        <= '0;
            button_clean <= 1'b1;
            press_pulse  <= 1'b1;
          end else begin
            count <= count_inc[CNT_W-1:0];
          end
        end
        S_HIGH: begin
          if (!sync2) begin
            state <= S_FALL_WAIT;
            count <= CNT_W'(1);
          end else begin
            count <= '0;
          end
        end
        S_FALL_WAIT: begin
          if (sync2) begin
            state <= S_HIGH;
            count <= '0;
          end else if (count_done) begin
            state         <= S_LOW;
            count         <= '0;
            button_clean  <= 1'b0;
            release_pulse <= 1'b1;
          end else begin
            count <= count_inc[CNT_W-1:0];
          end
        end
        default: begin
          state <= S_LOW;
          count <= '0;
        end
      endcase
    end
  end

`ifdef BUTTON_DEBOUNCER_LONG_PRESS_EN
  localparam logic [CNT_W:0] LP_LIM = (CNT_W + 1)'(LONG_PRESS_CYCLES);

  logic [CNT_W-1:0] lp_count;
  logic [CNT_W:0]   lp_inc;
  logic             leaving_high;

  assign lp_inc       = {1'b0, lp_count} + (CNT_W + 1)'(1);
  assign leaving_high = (state == S_FALL_WAIT) && !sync2 && count_done;

  // Saturates at the limit so the strobe fires once per hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      lp_count   <= '0;
      long_press <= 1'b0;
    end else begin
      long_press <= 1'b0;
      if (!button_clean || leaving_high) begin
        lp_count <= '0;
      end else if (lp_inc <= LP_LIM) begin
        lp_count <= lp_inc[CNT_W-1:0];
        if (lp_inc == LP_LIM) begin
          long_press <= 1'b1;
        end
      end
    end
  end
`else
  assign long_press = 1'b0;
`endif

endmodule

// File: tb/tb_button_debouncer.sv
// Directed bench for button_debouncer with DEBOUNCE_CYCLES=4, LONG_PRESS_CYCLES=10.
// Expected outputs are hand-derived edge by edge from the raw stimulus.
module tb_button_debouncer;

  localparam int DEB = 4;
  localparam int LPC = 10;
`ifdef BUTTON_DEBOUNCER_LONG_PRESS_EN
  localparam bit LP_EN = 1'b1;
`else
  localparam bit LP_EN = 1'b0;
`endif

  logic clk;
  logic rst;
  logic button_raw;
  logic button_clean;
  logic press_pulse;
  logic release_pulse;
  logic long_press;

  int checks;
  int errors;
  int since_rise;

  button_debouncer #(
    .DEBOUNCE_CYCLES  (DEB),
    .LONG_PRESS_CYCLES(LPC),
    .CNT_W            (8)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .button_raw   (button_raw),
    .button_clean (button_clean),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .long_press   (long_press)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Advance one edge, then check every output; long_press is expected
  // exactly LPC edges after the rising edge of button_clean.
  task automatic step(input string tag, input logic ec, input logic ep, input logic er);
    logic el;
    @(posedge clk);
    #1;
    if (!ec || ep) since_rise = 0;
    else since_rise++;
    el = LP_EN && ec && !ep && (since_rise == LPC);
    chk({tag, ".clean"},   button_clean,  ec);
    chk({tag, ".press"},   press_pulse,   ep);
    chk({tag, ".release"}, release_pulse, er);
    chk({tag, ".long"},    long_press,    el);
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    since_rise = 0;
    rst        = 1'b1;
    button_raw = 1'b0;

    // Reset state, including raw=1 during reset
    step("reset", 0, 0, 0);
    step("reset", 0, 0, 0);
    button_raw = 1'b1;
    step("reset_raw1", 0, 0, 0);
    step("reset_raw1", 0, 0, 0);
    button_raw = 1'b0;
    step("reset_flush", 0, 0, 0);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) step("idle", 0, 0, 0);

    // Clean press: edge 0 samples 1, clean rises after edge 5; hold for long press
    button_raw = 1'b1;
    for (int i = 0; i < 5; i++) step("press_wait", 0, 0, 0);
    step("press_rise", 1, 1, 0);
    for (int i = 0; i < 30; i++) step("press_hold", 1, 0, 0);

    // Release: clean falls after edge 5 with one release strobe
    button_raw = 1'b0;
    for (int i = 0; i < 5; i++) step("rel_wait", 1, 0, 0);
    step("rel_fall", 0, 0, 1);
    for (int i = 0; i < 3; i++) step("rel_low", 0, 0, 0);

    // Bounce: high 3, low 1, then high; rise 5 edges after last rising sample
    button_raw = 1'b1;
    for (int i = 0; i < 3; i++) step("bounce_hi", 0, 0, 0);
    button_raw = 1'b0;
    step("bounce_lo", 0, 0, 0);
    button_raw = 1'b1;
    for (int i = 0; i < 5; i++) step("bounce_wait", 0, 0, 0);
    step("bounce_rise", 1, 1, 0);
    for (int i = 0; i < 4; i++) step("bounce_hold", 1, 0, 0);

    // Two-cycle low glitch while high: no output change
    button_raw = 1'b0;
    for (int i = 0; i < 2; i++) step("glitch_lo", 1, 0, 0);
    button_raw = 1'b1;
    for (int i = 0; i < 8; i++) step("glitch_hold", 1, 0, 0);

    button_raw = 1'b0;
    for (int i = 0; i < 5; i++) step("rel2_wait", 1, 0, 0);
    step("rel2_fall", 0, 0, 1);
    step("rel2_low", 0, 0, 0);

    // Reset on 3rd count edge with raw held 1; rise 6 edges after deassertion
    button_raw = 1'b1;
    for (int i = 0; i < 4; i++) step("mid_wait", 0, 0, 0);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) step("mid_rst", 0, 0, 0);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) step("post_rst_wait", 0, 0, 0);
    step("post_rst_rise", 1, 1, 0);
    for (int i = 0; i < 3; i++) step("post_rst_hold", 1, 0, 0);

    // Reset while high: outputs drop with no release strobe
    rst        = 1'b1;
    button_raw = 1'b0;
    for (int i = 0; i < 2; i++) step("rst_high", 0, 0, 0);
    rst = 1'b0;
    for (int i = 0; i < 7; i++) step("rst_high_after", 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
